// File: rtl/conv_row_addr_gen_pkg.sv
// conv_row_addr_gen_pkg: shared FSM encoding and buffer-index values for the conv row address path.
package conv_row_addr_gen_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RUN, FIN} state_t;
  typedef logic [1:0] idx_t;
  localparam idx_t IDX_PAD = 2'd0;
  localparam idx_t IDX_FIRST = 2'd1;
  localparam idx_t IDX_LAST = 2'd3;
  function automatic idx_t idx_next(idx_t i);
    return (i == IDX_LAST) ? IDX_FIRST : i + 2'd1;
  endfunction
endpackage

// File: rtl/conv_row_addr_gen_if.sv
// conv_row_addr_gen_if: control inputs and window-row address/index outputs of conv_row_addr_gen.
interface conv_row_addr_gen_if #(parameter int CNT_W = 16);
  import conv_row_addr_gen_pkg::*;
  logic en, start, row_loaded;
  logic [CNT_W-1:0] words_per_row, img_rows;
  logic [CNT_W-1:0] row1_buf_adr, row2_buf_adr, row3_buf_adr;
  logic [CNT_W-1:0] row1_slab_adr, row2_slab_adr, row3_slab_adr;
  idx_t row1_buf_idx, row2_buf_idx, row3_buf_idx;
  idx_t row1_slab_idx, row2_slab_idx, row3_slab_idx;
  idx_t last_row1_buf_idx, last_row2_buf_idx, last_row3_buf_idx;
  idx_t last_row1_slab_idx, last_row2_slab_idx, last_row3_slab_idx;
  logic valid_row1_adr, valid_row2_adr, valid_row3_adr;
  logic row_free, busy, done;
  modport master (
    output en, start, row_loaded, words_per_row, img_rows,
    input row1_buf_adr, row2_buf_adr, row3_buf_adr, row1_slab_adr, row2_slab_adr, row3_slab_adr,
    input row1_buf_idx, row2_buf_idx, row3_buf_idx, row1_slab_idx, row2_slab_idx, row3_slab_idx,
    input last_row1_buf_idx, last_row2_buf_idx, last_row3_buf_idx,
    input last_row1_slab_idx, last_row2_slab_idx, last_row3_slab_idx,
    input valid_row1_adr, valid_row2_adr, valid_row3_adr, row_free, busy, done
  );
  modport slave (
    input en, start, row_loaded, words_per_row, img_rows,
    output row1_buf_adr, row2_buf_adr, row3_buf_adr, row1_slab_adr, row2_slab_adr, row3_slab_adr,
    output row1_buf_idx, row2_buf_idx, row3_buf_idx, row1_slab_idx, row2_slab_idx, row3_slab_idx,
    output last_row1_buf_idx, last_row2_buf_idx, last_row3_buf_idx,
    output last_row1_slab_idx, last_row2_slab_idx, last_row3_slab_idx,
    output valid_row1_adr, valid_row2_adr, valid_row3_adr, row_free, busy, done
  );
endinterface

// File: rtl/conv_row_addr_gen_ring_idx3.sv
// ring_idx3: buffer index register rotating 1->2->3->1 on each advance; clr reloads the start value.
module ring_idx3
  import conv_row_addr_gen_pkg::*;
#(
  parameter idx_t INIT = IDX_FIRST
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  input  logic adv_i,
  output idx_t idx_o
);
  idx_t idx_q, idx_d;
  always_comb idx_d = clr_i ? INIT : adv_i ? idx_next(idx_q) : idx_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idx_q <= INIT;
    else if (en_i) idx_q <= idx_d;
  assign idx_o = idx_q;
endmodule

// File: rtl/conv_row_addr_gen.sv
// conv_row_addr_gen: walks a frame row by row, emitting column addresses and ring-buffer indices
// for a 3-row convolution window with zero-padding above the first and below the last row.
module conv_row_addr_gen
  import conv_row_addr_gen_pkg::*;
#(
  parameter int pixels_in_row = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  conv_row_addr_gen_if.slave bus
);
  localparam logic [CNT_W-1:0] ONE = 1;
  if (pixels_in_row < 1) begin : g_bad_param
    $error("pixels_in_row must be positive");
  end
  state_t state_q, state_d;
  logic [CNT_W-1:0] col_q, col_d, r_q, r_d, loaded_q, loaded_d, rows_q, rows_d, wpr_q, wpr_d;
  logic [CNT_W:0] r2, need;
  logic free_q, free_d, adv, clr, run;
  logic [5:0] last_q;
  idx_t ia, ib, ic, idx1, idx2, idx3;
  // ia/ib/ic track rows r, r+1 and r+2 (== r-1 mod 3)
  ring_idx3 #(.INIT(2'd1)) u_ring_a (.clk, .rst_n, .en_i(bus.en), .clr_i(clr), .adv_i(adv), .idx_o(ia));
  ring_idx3 #(.INIT(2'd2)) u_ring_b (.clk, .rst_n, .en_i(bus.en), .clr_i(clr), .adv_i(adv), .idx_o(ib));
  ring_idx3 #(.INIT(2'd3)) u_ring_c (.clk, .rst_n, .en_i(bus.en), .clr_i(clr), .adv_i(adv), .idx_o(ic));
  assign r2 = {1'b0, r_q} + (CNT_W+1)'(2);
  assign need = (r2 < {1'b0, rows_q}) ? r2 : {1'b0, rows_q};
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    r_d = r_q;
    rows_d = rows_q;
    wpr_d = wpr_q;
    adv = 1'b0;
    clr = 1'b0;
    free_d = 1'b0;
    loaded_d = (state_q != IDLE && bus.row_loaded && loaded_q < rows_q) ? loaded_q + ONE : loaded_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = WAIT;
        clr = 1'b1;
        col_d = '0;
        r_d = '0;
        loaded_d = '0;
        rows_d = bus.img_rows;
        wpr_d = bus.words_per_row;
      end
      WAIT: if ({1'b0, loaded_q} >= need) state_d = RUN;
      RUN: if (col_q == wpr_q - ONE) begin
        col_d = '0;
        if (r_q == rows_q - ONE) state_d = FIN;
        else begin
          state_d = WAIT;
          r_d = r_q + ONE;
          adv = 1'b1;
          free_d = r_q != '0;
        end
      end else col_d = col_q + ONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      col_q <= '0;
      r_q <= '0;
      loaded_q <= '0;
      rows_q <= '0;
      wpr_q <= '0;
      free_q <= 1'b0;
      last_q <= '0;
    end else begin
      free_q <= bus.en && free_d;
      if (bus.en) begin
        state_q <= state_d;
        col_q <= col_d;
        r_q <= r_d;
        loaded_q <= loaded_d;
        rows_q <= rows_d;
        wpr_q <= wpr_d;
        last_q <= {idx1, idx2, idx3};
      end
    end
  assign run = state_q == RUN;
  assign idx1 = (run && r_q != '0) ? ic : IDX_PAD;
  assign idx2 = run ? ia : IDX_PAD;
  assign idx3 = (run && r_q != rows_q - ONE) ? ib : IDX_PAD;
  assign bus.row1_buf_adr = run ? col_q : '0;
  assign bus.row2_buf_adr = run ? col_q : '0;
  assign bus.row3_buf_adr = run ? col_q : '0;
  assign bus.row1_slab_adr = run ? col_q : '0;
  assign bus.row2_slab_adr = run ? col_q : '0;
  assign bus.row3_slab_adr = run ? col_q : '0;
  assign bus.row1_buf_idx = idx1;
  assign bus.row2_buf_idx = idx2;
  assign bus.row3_buf_idx = idx3;
  assign bus.row1_slab_idx = idx1;
  assign bus.row2_slab_idx = idx2;
  assign bus.row3_slab_idx = idx3;
  assign bus.last_row1_buf_idx = last_q[5:4];
  assign bus.last_row2_buf_idx = last_q[3:2];
  assign bus.last_row3_buf_idx = last_q[1:0];
  assign bus.last_row1_slab_idx = last_q[5:4];
  assign bus.last_row2_slab_idx = last_q[3:2];
  assign bus.last_row3_slab_idx = last_q[1:0];
  assign bus.valid_row1_adr = run && bus.en && idx1 != IDX_PAD;
  assign bus.valid_row2_adr = run && bus.en && idx2 != IDX_PAD;
  assign bus.valid_row3_adr = run && bus.en && idx3 != IDX_PAD;
  assign bus.row_free = free_q;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == FIN && bus.en;
endmodule

// File: tb/tb_conv_row_addr_gen.sv
// tb_conv_row_addr_gen: directed frames with an expected-output queue drained by a negedge monitor.
module tb_conv_row_addr_gen;
  logic clk = 1'b0, rst_n = 1'b1, clk_en = 1'b1;
  always #5 clk = clk_en ? ~clk : 1'b0;
  conv_row_addr_gen_if #(.CNT_W(16)) b ();
  conv_row_addr_gen #(.pixels_in_row(32), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  typedef struct {
    logic [15:0] adr;
    logic [1:0] i1, i2, i3, l1, l2, l3;
    logic v1, v2, v3;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int nassert = 0, nfail = 0, pops = 0, dones = 0, frees = 0;
  function automatic int ridx(int k, int rows);
    return (k < 0 || k >= rows) ? 0 : (k % 3) + 1;
  endfunction
  task automatic chk(string nm, logic [255:0] act, logic [255:0] req);
    nassert++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(string nm);
    chk(nm, {b.row1_buf_adr, b.row2_buf_adr, b.row3_buf_adr, b.row1_slab_adr, b.row2_slab_adr, b.row3_slab_adr,
             b.row1_buf_idx, b.row2_buf_idx, b.row3_buf_idx, b.row1_slab_idx, b.row2_slab_idx, b.row3_slab_idx,
             b.last_row1_buf_idx, b.last_row2_buf_idx, b.last_row3_buf_idx,
             b.last_row1_slab_idx, b.last_row2_slab_idx, b.last_row3_slab_idx,
             b.valid_row1_adr, b.valid_row2_adr, b.valid_row3_adr, b.row_free, b.busy, b.done}, '0);
  endtask
  task automatic push_frame(int wpr, int rows);
    exp_t x;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < wpr; c++) begin
        x.adr = 16'(c);
        x.i1 = 2'(ridx(r - 1, rows));
        x.i2 = 2'(ridx(r, rows));
        x.i3 = 2'(ridx(r + 1, rows));
        x.v1 = x.i1 != 0;
        x.v2 = x.i2 != 0;
        x.v3 = x.i3 != 0;
        x.l1 = (c == 0) ? 2'd0 : x.i1;
        x.l2 = (c == 0) ? 2'd0 : x.i2;
        x.l3 = (c == 0) ? 2'd0 : x.i3;
        q.push_back(x);
      end
  endtask
  task automatic start_frame(int wpr, int rows, int pre);
    b.words_per_row = 16'(wpr);
    b.img_rows = 16'(rows);
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
    for (int i = 0; i < pre; i++) begin
      b.row_loaded = 1'b1;
      tick();
    end
    b.row_loaded = 1'b0;
  endtask
  task automatic frame(int wpr, int rows, int pre, bit gaps, bit stall);
    int d0, f0, p0, n;
    d0 = dones;
    f0 = frees;
    p0 = pops;
    push_frame(wpr, rows);
    start_frame(wpr, rows, pre);
    if (stall) begin
      repeat (40) tick();
      chk("stall_pops", pops - p0, 2 * wpr);
      chk("stall_busy", b.busy, 1);
      b.img_rows = 16'd1;
      b.start = 1'b1;
      tick();
      b.start = 1'b0;
      b.img_rows = 16'(rows);
      repeat (3) tick();
      chk("start_ignored_pops", pops - p0, 2 * wpr);
      b.row_loaded = 1'b1;
      tick();
      b.row_loaded = 1'b0;
    end
    n = 0;
    while (dones == d0 && n < 5000) begin
      if (gaps) b.en = (n % 3) != 1;
      tick();
      n++;
    end
    b.en = 1'b1;
    tick();
    chk("done_cnt", dones - d0, 1);
    chk("row_free_cnt", frees - f0, (rows >= 2) ? rows - 2 : 0);
    chk("items_left", q.size(), 0);
    chk("busy_after_done", b.busy, 0);
  endtask
  always @(negedge clk) if (rst_n) begin
    if (b.done) dones++;
    if (b.row_free) frees++;
    if (!b.en) chk("valid_while_en0", {b.valid_row1_adr, b.valid_row2_adr, b.valid_row3_adr}, 0);
    if (b.valid_row2_adr) begin
      if (q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        e = q.pop_front();
        pops++;
        chk("adr", {b.row1_buf_adr, b.row2_buf_adr, b.row3_buf_adr, b.row1_slab_adr, b.row2_slab_adr, b.row3_slab_adr},
            {6{e.adr}});
        chk("idx", {b.row1_buf_idx, b.row2_buf_idx, b.row3_buf_idx, b.row1_slab_idx, b.row2_slab_idx, b.row3_slab_idx},
            {e.i1, e.i2, e.i3, e.i1, e.i2, e.i3});
        chk("valid", {b.valid_row1_adr, b.valid_row2_adr, b.valid_row3_adr}, {e.v1, e.v2, e.v3});
        chk("last", {b.last_row1_buf_idx, b.last_row2_buf_idx, b.last_row3_buf_idx,
                     b.last_row1_slab_idx, b.last_row2_slab_idx, b.last_row3_slab_idx},
            {e.l1, e.l2, e.l3, e.l1, e.l2, e.l3});
      end
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int d0, f0, p0, n;
    b.en = 1'b1;
    b.start = 1'b0;
    b.row_loaded = 1'b0;
    b.words_per_row = 16'd4;
    b.img_rows = 16'd3;
    #2 rst_n = 1'b0;
    #1 chk_zero("reset_outputs");
    #20 rst_n = 1'b1;
    tick();
    tick();
    chk("idle_busy", b.busy, 0);
    frame(4, 3, 3, 1'b0, 1'b0);
    frame(4, 4, 3, 1'b0, 1'b1);
    frame(4, 3, 3, 1'b1, 1'b0);
    d0 = dones;
    f0 = frees;
    p0 = pops;
    push_frame(4, 3);
    start_frame(4, 3, 3);
    n = 0;
    while (pops < p0 + 6 && n < 200) begin
      tick();
      n++;
    end
    chk("midframe_reached", pops - p0 >= 6, 1);
    clk_en = 1'b0;
    #10 rst_n = 1'b0;
    #1 chk_zero("async_reset_outputs");
    q.delete();
    #5 rst_n = 1'b1;
    clk_en = 1'b1;
    repeat (3) tick();
    chk("abort_no_done", dones - d0, 0);
    chk("abort_no_free", frees - f0, 0);
    chk("abort_idle", b.busy, 0);
    frame(4, 1, 1, 1'b0, 1'b0);
    frame(2, 7, 7, 1'b0, 1'b0);
    frame(1, 3, 3, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
